// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - time-multiplexed fade stepper for PWM channel levels
// One shared step/saturate datapath visits one channel per clock in sweeps paced by frame_tick.
module pwm_fade_sequencer #(
  parameter int NUM_CH   = 4,
  parameter int TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_ch,
  input  logic [7:0]            cfg_target,
  input  logic [7:0]            cfg_step,
  output logic [8*NUM_CH-1:0]   level_out,
  output logic [NUM_CH-1:0]     ramp_active,
  output logic                  ramp_done,
  output logic [2:0]            done_ch
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          r_state;
  logic [7:0]      r_cur [NUM_CH];
  logic [7:0]      r_tgt [NUM_CH];
  logic [7:0]      r_stp [NUM_CH];
  logic [DW-1:0]   r_div_cnt;
  logic            r_pending;
  logic [IW-1:0]   r_idx;
  logic            r_ramp_done;
  logic [2:0]      r_done_ch;

  logic            w_req;
  logic            w_cfg_wr;
  logic            w_cfg_hit;
  logic            w_last;
  logic [7:0]      w_cur;
  logic [7:0]      w_tgt;
  logic [7:0]      w_stp;
  logic [8:0]      w_sum;
  logic signed [8:0] w_dif;
  logic [7:0]      w_next;

  assign w_req     = frame_tick && (r_div_cnt == DW'(TICK_DIV - 1));
  assign cfg_ready = (r_state == IDLE);
  assign w_cfg_wr  = cfg_valid && cfg_ready;
  assign w_cfg_hit = ({1'b0, cfg_ch} < 4'(NUM_CH));
  assign w_last    = (r_idx == IW'(NUM_CH - 1));

  assign w_cur = r_cur[r_idx];
  assign w_tgt = r_tgt[r_idx];
  assign w_stp = r_stp[r_idx];

  // Widened arithmetic so the step can overshoot and be clamped instead of wrapping.
  assign w_sum = {1'b0, w_cur} + {1'b0, w_stp};
  assign w_dif = $signed({1'b0, w_cur}) - $signed({1'b0, w_stp});

  always_comb begin
    w_next = w_tgt;
    if (w_stp != 8'd0) begin
      if (w_cur < w_tgt)
        w_next = (w_sum > {1'b0, w_tgt}) ? w_tgt : w_sum[7:0];
      else if (w_cur > w_tgt)
        w_next = (w_dif < $signed({1'b0, w_tgt})) ? w_tgt : w_dif[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cur[i] <= 8'd0;
        r_tgt[i] <= 8'd0;
        r_stp[i] <= 8'd0;
      end
      r_state     <= IDLE;
      r_div_cnt   <= '0;
      r_pending   <= 1'b0;
      r_idx       <= '0;
      r_ramp_done <= 1'b0;
      r_done_ch   <= 3'd0;
    end else begin
      if (frame_tick)
        r_div_cnt <= w_req ? '0 : r_div_cnt + 1'b1;
      if (w_cfg_wr && w_cfg_hit) begin
        r_tgt[cfg_ch[IW-1:0]] <= cfg_target;
        r_stp[cfg_ch[IW-1:0]] <= cfg_step;
      end
      r_ramp_done <= 1'b0;
      if (r_state == IDLE) begin
        if (w_req || r_pending) begin
          r_state   <= SWEEP;
          r_idx     <= '0;
          r_pending <= 1'b0;
        end
      end else begin
        r_cur[r_idx] <= w_next;
        if ((w_cur != w_tgt) && (w_next == w_tgt)) begin
          r_ramp_done <= 1'b1;
          r_done_ch   <= 3'(r_idx);
        end
        // A held request chains straight into the next sweep without an IDLE gap.
        if (w_last) begin
          r_idx     <= '0;
          r_state   <= r_pending ? SWEEP : IDLE;
          r_pending <= w_req;
        end else begin
          r_idx <= r_idx + 1'b1;
          if (w_req)
            r_pending <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign level_out[8*g +: 8] = r_cur[g];
    assign ramp_active[g]      = (r_cur[g] != r_tgt[g]);
  end

  assign ramp_done = r_ramp_done;
  assign done_ch   = r_done_ch;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb/tb_pwm_fade_sequencer.sv - directed table-driven bench for pwm_fade_sequencer
// Runs with NUM_CH=4, TICK_DIV=2; two frame_ticks launch one sweep.
module tb_pwm_fade_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_ch;
  logic [7:0]  cfg_target;
  logic [7:0]  cfg_step;
  logic [31:0] level_out;
  logic [3:0]  ramp_active;
  logic        ramp_done;
  logic [2:0]  done_ch;

  int n_cmp = 0;
  int n_err = 0;

  pwm_fade_sequencer #(.NUM_CH(4), .TICK_DIV(2)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_target(cfg_target), .cfg_step(cfg_step), .level_out(level_out),
    .ramp_active(ramp_active), .ramp_done(ramp_done), .done_ch(done_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [2:0]  ch;
    logic [7:0]  tgt;
    logic [7:0]  stp;
    logic [31:0] lvl;
    logic [3:0]  act;
    int          nd;
    logic [2:0]  dch;
  } vec_t;

  vec_t tbl [12];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [7:0] t, input logic [7:0] s);
    int n;
    cfg_valid = 1'b1; cfg_ch = ch; cfg_target = t; cfg_step = s;
    n = 0;
    while (!cfg_ready && n < 50) begin cyc(); n++; end
    if (n >= 50) chk("cfg_write_timeout", 32'(n), 32'd0);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic run_sweep(output int dones, output logic [2:0] dch, output int busy);
    dones = 0; dch = 3'd0; busy = 0;
    frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!cfg_ready) busy++;
      if (ramp_done) begin dones++; dch = done_ch; end
      if (cfg_ready && busy > 0) break;
      cyc();
    end
  endtask

  initial begin
    int nd, busy, n;
    logic [2:0] dch;
    logic early;

    tbl[0]  = '{1'b1, 3'd0, 8'd10,  8'd4,   32'h0000_0004, 4'b0001, 0, 3'd0};
    tbl[1]  = '{1'b0, 3'd0, 8'd0,   8'd0,   32'h0000_0008, 4'b0001, 0, 3'd0};
    tbl[2]  = '{1'b0, 3'd0, 8'd0,   8'd0,   32'h0000_000A, 4'b0000, 1, 3'd0};
    tbl[3]  = '{1'b1, 3'd1, 8'd200, 8'd0,   32'h0000_C80A, 4'b0000, 1, 3'd1};
    tbl[4]  = '{1'b1, 3'd1, 8'd5,   8'd100, 32'h0000_640A, 4'b0010, 0, 3'd0};
    tbl[5]  = '{1'b0, 3'd0, 8'd0,   8'd0,   32'h0000_050A, 4'b0000, 1, 3'd1};
    tbl[6]  = '{1'b1, 3'd2, 8'd100, 8'd0,   32'h0064_050A, 4'b0000, 1, 3'd2};
    tbl[7]  = '{1'b1, 3'd2, 8'd255, 8'd200, 32'h00FF_050A, 4'b0000, 1, 3'd2};
    tbl[8]  = '{1'b1, 3'd3, 8'd250, 8'd0,   32'hFAFF_050A, 4'b0000, 1, 3'd3};
    tbl[9]  = '{1'b1, 3'd3, 8'd0,   8'd255, 32'h00FF_050A, 4'b0000, 1, 3'd3};
    tbl[10] = '{1'b1, 3'd5, 8'd77,  8'd1,   32'h00FF_050A, 4'b0000, 0, 3'd0};
    tbl[11] = '{1'b1, 3'd0, 8'd10,  8'd3,   32'h00FF_050A, 4'b0000, 0, 3'd0};

    reset = 1'b0; frame_tick = 1'b0; cfg_valid = 1'b0;
    cfg_ch = 3'd0; cfg_target = 8'd0; cfg_step = 8'd0;
    cyc(); cyc();
    reset = 1'b1;

    // Activity then reset held two cycles while a sweep is running.
    cfg_write(3'd0, 8'd99, 8'd0);
    frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0; cyc();
    reset = 1'b0; cyc(); cyc();
    reset = 1'b1;
    chk("rst_level", level_out, 32'd0);
    chk("rst_active", 32'(ramp_active), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_done", 32'(ramp_done), 32'd0);
    cyc(); cyc();
    chk("rst_idle_hold", {31'd0, cfg_ready}, 32'd1);
    chk("rst_level_hold", level_out, 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) cfg_write(tbl[i].ch, tbl[i].tgt, tbl[i].stp);
      run_sweep(nd, dch, busy);
      chk($sformatf("v%0d_level", i), level_out, tbl[i].lvl);
      chk($sformatf("v%0d_active", i), 32'(ramp_active), 32'(tbl[i].act));
      chk($sformatf("v%0d_ndone", i), 32'(nd), 32'(tbl[i].nd));
      chk($sformatf("v%0d_sweeplen", i), 32'(busy), 32'd4);
      if (tbl[i].nd > 0) chk($sformatf("v%0d_done_ch", i), 32'(dch), 32'(tbl[i].dch));
    end

    // Write held during a sweep is stalled until the first IDLE cycle.
    frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0;
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_target = 8'd50; cfg_step = 8'd0;
    chk("hs_ready_low", 32'(cfg_ready), 32'd0);
    n = 0; early = 1'b0;
    while (!cfg_ready && n < 20) begin
      if (ramp_active[0]) early = 1'b1;
      cyc(); n++;
    end
    chk("hs_no_early_accept", 32'(early), 32'd0);
    chk("hs_wait_cycles", 32'(n), 32'd4);
    cyc();
    cfg_valid = 1'b0;
    chk("hs_accepted", 32'(ramp_active), 32'b0001);
    run_sweep(nd, dch, busy);
    chk("hs_level", level_out, 32'h00FF_0532);
    chk("hs_done_ch", 32'(dch), 32'd0);

    // Mid-sweep request chains a second sweep; write coincident with request applies first.
    cfg_write(3'd2, 8'd235, 8'd10);
    frame_tick = 1'b1; cyc();
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_target = 8'd9; cfg_step = 8'd0;
    cyc();
    frame_tick = 1'b0; cfg_valid = 1'b0;
    busy = 0; nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (!cfg_ready) busy++;
      if (ramp_done) nd++;
      if (cfg_ready && busy > 0) break;
      frame_tick = (i < 2);
      cyc();
    end
    frame_tick = 1'b0;
    chk("pend_busy_cycles", 32'(busy), 32'd8);
    chk("pend_ndone", 32'(nd), 32'd2);
    chk("pend_level", level_out, 32'h09EB_0532);

    // Reset during idx=2 must clear everything, including the ramp_done from idx=1.
    cfg_write(3'd0, 8'd0, 8'd25);
    cfg_write(3'd1, 8'd6, 8'd0);
    frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0;
    cyc(); cyc();
    chk("mid_level_pre", level_out, 32'h09EB_0619);
    chk("mid_done_pre", 32'(ramp_done), 32'd1);
    chk("mid_done_ch_pre", 32'(done_ch), 32'd1);
    reset = 1'b0; cyc(); reset = 1'b1;
    chk("mid_rst_level", level_out, 32'd0);
    chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
    chk("mid_rst_done", 32'(ramp_done), 32'd0);
    chk("mid_rst_active", 32'(ramp_active), 32'd0);
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (ramp_done || level_out != 32'd0 || !cfg_ready) early = 1'b1;
    end
    chk("mid_rst_quiet", 32'(early), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
